pipe_ctl: RTL
=============

PIPE_CTL -- requirements
Module: pipe_ctl

Interface
REQ-001 SHALL have ports: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-002 SHALL have inputs: op_ld_or_ldr_alu 1 (LD/LDR in ALU stage); rc_alu 5 (ALU-stage destination); ra_rf 5, rb_rf 5 (RF-stage source addresses); ra_used_rf 1, rb_used_rf 1 (RF stage reads Ra/Rb).
REQ-003 SHALL have inputs: br_taken_rf 1 (branch/JMP resolved taken in RF stage); mem_req 1 (MEM stage issues a data access); mem_rdy 1 (data memory completes this cycle); irq 1 (level-sensitive external interrupt).
REQ-004 SHALL have outputs: stall_if 1, stall_rf 1, stall_alu 1, stall_mem 1 (hold stage register); annul_if 1, annul_rf 1, annul_mem 1 (inject NOP into next stage).
REQ-005 SHALL have outputs: pc_sel_xadr 1 (IF loads interrupt vector); irq_ack 1 (one-cycle pulse); stall_cnt 16 (saturating stall-cycle count).

Function
REQ-006 SHALL implement FSM states RUN, MEM_WAIT, IRQ_INJ; encoding free; reset state RUN.
REQ-007 SHALL define load_use = op_ld_or_ldr_alu & (rc_alu != 31) & ((ra_used_rf & ra_rf == rc_alu) | (rb_used_rf & rb_rf == rc_alu)); R31 never creates a hazard.
REQ-008 SHALL define mem_stall = mem_req & ~mem_rdy, evaluated combinationally in every state.
REQ-009 RUN, mem_stall=1: assert stall_if/rf/alu/mem and annul_mem same cycle; next state MEM_WAIT.
REQ-010 MEM_WAIT: stall_if/rf/alu/mem=1, annul_mem=1 while mem_rdy=0; on mem_rdy=1 all stalls deassert that cycle, next state RUN.
REQ-011 RUN, no mem_stall, load_use=1: stall_if=1, stall_rf=1, annul_rf=1 for exactly that cycle; ALU/MEM advance.
REQ-012 RUN, no mem_stall, no load_use, br_taken_rf=1: annul_if=1 for one cycle (squash fetched instruction).
REQ-013 RUN, no mem_stall, no load_use, irq=1: pc_sel_xadr=1, annul_if=1, irq_ack=1 for one cycle; next state IRQ_INJ.
REQ-014 IRQ_INJ: annul_if=1 one cycle, irq_ack=0, irq ignored; next state RUN (minimum two bubbles per interrupt, no re-entry before RUN).
REQ-015 Priority each cycle SHALL be mem_stall > load_use > irq > br_taken_rf; a lower-priority event while a higher one is active SHALL produce no outputs and SHALL be re-evaluated next cycle from its live inputs.
REQ-016 irq with br_taken_rf same cycle: interrupt taken, annul_if=1 once, branch target discarded.
REQ-017 stall_cnt SHALL increment by 1 on each clk edge where stall_if=1, saturate at 16'hFFFF, never wrap.
REQ-018 All outputs except stall_cnt SHALL be combinational from state and inputs; stall_cnt and state SHALL be registered.
REQ-019 Outputs not asserted by a rule above SHALL be 0.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state RUN and stall_cnt 0, independent of clk.
REQ-021 While rst_n=0, all stall_*, annul_*, pc_sel_xadr, irq_ack SHALL be 0.
REQ-022 Reset asserted during MEM_WAIT or IRQ_INJ SHALL abandon the sequence; first cycle after release evaluates from RUN.

Configuration
REQ-023 Macro PIPE_CTL_IRQ_EN defined: interrupt logic per REQ-013/014/016 present.
REQ-024 PIPE_CTL_IRQ_EN undefined: IRQ_INJ state absent, irq ignored, pc_sel_xadr and irq_ack tied 0; all other behaviour identical.

Verification
REQ-025 Load-use: op_ld_or_ldr_alu=1, rc_alu=3, ra_rf=3, ra_used_rf=1 one cycle -> stall_if=stall_rf=annul_rf=1 that cycle only, stall_cnt 0->1.
REQ-026 R31 case: same as REQ-025 with rc_alu=31, ra_rf=31 -> no stall, stall_cnt unchanged.
REQ-027 Memory wait: mem_req=1, mem_rdy=0 for 4 cycles then mem_rdy=1 -> all four stalls + annul_mem high 4 cycles, low on the 5th, stall_cnt=4, state back to RUN.
REQ-028 Simultaneous: mem_stall and irq together 2 cycles, then mem_rdy=1 with irq still 1 -> irq_ack pulses only the cycle after MEM_WAIT exits; with PIPE_CTL_IRQ_EN undefined, irq_ack stays 0.
REQ-029 Branch+irq: br_taken_rf=1, irq=1 same cycle -> pc_sel_xadr=1, irq_ack=1, annul_if=1 two consecutive cycles, irq_ack single pulse.
REQ-030 Saturation/reset: hold mem_stall 70000 cycles -> stall_cnt=16'hFFFF; drop rst_n mid-MEM_WAIT -> stall_cnt=0 and all stalls 0 immediately.

Source files
------------

// File: rtl/pipe_ctl_if.sv
// pipe_ctl_if
//   Groups the pipeline hazard/stall handshake between the stage logic and
//   the pipeline controller.
//   master : stage logic side. Drives the hazard sources and samples the
//            stall/annul/vector controls.
//   slave  : the controller (pipe_ctl). Samples the hazard sources and
//            drives the controls.
//   Hazard sources : op_ld_or_ldr_alu, rc_alu, ra_rf, rb_rf, ra_used_rf,
//                    rb_used_rf, br_taken_rf, mem_req, mem_rdy, irq
//   Controls       : stall_if/rf/alu/mem, annul_if/rf/mem, pc_sel_xadr,
//                    irq_ack, stall_cnt
interface pipe_ctl_if;
   logic        op_ld_or_ldr_alu;
   logic [4:0]  rc_alu;
   logic [4:0]  ra_rf;
   logic [4:0]  rb_rf;
   logic        ra_used_rf;
   logic        rb_used_rf;
   logic        br_taken_rf;
   logic        mem_req;
   logic        mem_rdy;
   logic        irq;

   logic        stall_if;
   logic        stall_rf;
   logic        stall_alu;
   logic        stall_mem;
   logic        annul_if;
   logic        annul_rf;
   logic        annul_mem;
   logic        pc_sel_xadr;
   logic        irq_ack;
   logic [15:0] stall_cnt;

   modport master (
      output op_ld_or_ldr_alu, rc_alu, ra_rf, rb_rf, ra_used_rf, rb_used_rf,
             br_taken_rf, mem_req, mem_rdy, irq,
      input  stall_if, stall_rf, stall_alu, stall_mem, annul_if, annul_rf,
             annul_mem, pc_sel_xadr, irq_ack, stall_cnt
   );

   modport slave (
      input  op_ld_or_ldr_alu, rc_alu, ra_rf, rb_rf, ra_used_rf, rb_used_rf,
             br_taken_rf, mem_req, mem_rdy, irq,
      output stall_if, stall_rf, stall_alu, stall_mem, annul_if, annul_rf,
             annul_mem, pc_sel_xadr, irq_ack, stall_cnt
   );
endinterface

// File: rtl/pipe_ctl.sv
// pipe_ctl
//   Pipeline hazard controller: memory-wait stalls, load-use interlock,
//   taken-branch squash and interrupt injection, plus a saturating count of
//   fetch-stall cycles.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset (forces RUN, clears stall_cnt,
//             holds every control output low while asserted)
//     bus   : pipe_ctl_if.slave -- hazard sources in, stage controls out
//   Configuration:
//     PIPE_CTL_IRQ_EN : when defined, interrupt injection (IRQ_INJ state,
//                       pc_sel_xadr, irq_ack) is built; otherwise irq is
//                       ignored and pc_sel_xadr/irq_ack stay 0.
//   Priority each cycle: mem_stall > load_use > irq > br_taken_rf.
module pipe_ctl (
   input  logic        clk,
   input  logic        rst_n,
   pipe_ctl_if.slave   bus
);

`ifdef PIPE_CTL_IRQ_EN
   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, IRQ_INJ = 2'd2} state_t;
`else
   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1} state_t;
`endif

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_stall_cnt;

   logic w_load_use;
   logic w_mem_stall;
   logic w_stall_if, w_stall_rf, w_stall_alu, w_stall_mem;
   logic w_annul_if, w_annul_rf, w_annul_mem;
   logic w_pc_sel_xadr, w_irq_ack;

   // R31 is the hard-wired zero register and can never carry a hazard.
   assign w_load_use = bus.op_ld_or_ldr_alu && (bus.rc_alu != 5'd31) &&
                       ((bus.ra_used_rf && (bus.ra_rf == bus.rc_alu)) ||
                        (bus.rb_used_rf && (bus.rb_rf == bus.rc_alu)));

   assign w_mem_stall = bus.mem_req && !bus.mem_rdy;

   always_comb begin
      w_next        = r_state;
      w_stall_if    = 1'b0;
      w_stall_rf    = 1'b0;
      w_stall_alu   = 1'b0;
      w_stall_mem   = 1'b0;
      w_annul_if    = 1'b0;
      w_annul_rf    = 1'b0;
      w_annul_mem   = 1'b0;
      w_pc_sel_xadr = 1'b0;
      w_irq_ack     = 1'b0;

      case (r_state)
         RUN: begin
            if (w_mem_stall) begin
               {w_stall_if, w_stall_rf, w_stall_alu, w_stall_mem} = '1;
               w_annul_mem = 1'b1;
               w_next      = MEM_WAIT;
            end else if (w_load_use) begin
               w_stall_if = 1'b1;
               w_stall_rf = 1'b1;
               w_annul_rf = 1'b1;
`ifdef PIPE_CTL_IRQ_EN
            end else if (bus.irq) begin
               // A coincident taken branch is dropped: the vector wins.
               w_pc_sel_xadr = 1'b1;
               w_annul_if    = 1'b1;
               w_irq_ack     = 1'b1;
               w_next        = IRQ_INJ;
`endif
            end else if (bus.br_taken_rf) begin
               w_annul_if = 1'b1;
            end
         end

         MEM_WAIT: begin
            if (!bus.mem_rdy) begin
               {w_stall_if, w_stall_rf, w_stall_alu, w_stall_mem} = '1;
               w_annul_mem = 1'b1;
            end else begin
               w_next = RUN;
            end
         end

`ifdef PIPE_CTL_IRQ_EN
         // Second interrupt bubble. Higher-priority stalls hold the bubble
         // pending here so an interrupt always costs two annulled fetches.
         IRQ_INJ: begin
            if (w_mem_stall) begin
               {w_stall_if, w_stall_rf, w_stall_alu, w_stall_mem} = '1;
               w_annul_mem = 1'b1;
            end else if (w_load_use) begin
               w_stall_if = 1'b1;
               w_stall_rf = 1'b1;
               w_annul_rf = 1'b1;
            end else begin
               w_annul_if = 1'b1;
               w_next     = RUN;
            end
         end
`endif

         default: w_next = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_stall_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_stall_if && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   // Controls are forced low during reset regardless of inputs.
   assign bus.stall_if    = rst_n && w_stall_if;
   assign bus.stall_rf    = rst_n && w_stall_rf;
   assign bus.stall_alu   = rst_n && w_stall_alu;
   assign bus.stall_mem   = rst_n && w_stall_mem;
   assign bus.annul_if    = rst_n && w_annul_if;
   assign bus.annul_rf    = rst_n && w_annul_rf;
   assign bus.annul_mem   = rst_n && w_annul_mem;
   assign bus.pc_sel_xadr = rst_n && w_pc_sel_xadr;
   assign bus.irq_ack     = rst_n && w_irq_ack;
   assign bus.stall_cnt   = r_stall_cnt;

endmodule
